// File: rtl/ssm_tile_feeder.sv
// Ping-pong staging buffer for the SSM block: collects one group of TPG tiles
// from a bursty valid/ready source, then replays it as a gap-free tile burst.
module ssm_tile_feeder #(
  parameter int DW      = 16,
  parameter int N_TILE  = 16,
  parameter int N_TOTAL = 128,
  localparam int TPG    = N_TOTAL / N_TILE,
  localparam int IW     = $clog2(TPG),
  localparam int TW     = N_TILE * DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_dt_i,
  input  logic [DW-1:0] in_dA_i,
  input  logic [DW-1:0] in_x_i,
  input  logic [DW-1:0] in_D_i,
  input  logic [TW-1:0] in_B_tile_i,
  input  logic [TW-1:0] in_C_tile_i,
  input  logic [TW-1:0] in_hprev_tile_i,
  output logic          tile_valid_o,
  output logic [DW-1:0] dt_o,
  output logic [DW-1:0] dA_o,
  output logic [DW-1:0] x_o,
  output logic [DW-1:0] D_o,
  output logic [TW-1:0] B_tile_o,
  output logic [TW-1:0] C_tile_o,
  output logic [TW-1:0] hprev_tile_o,
  output logic [IW-1:0] tile_idx_o,
  output logic          group_last_o,
  output logic [15:0]   groups_sent_o
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e        state_q, state_d;
  logic [1:0]    full_q, full_d;
  logic          wbank_q, wbank_d;
  logic [IW-1:0] wcnt_q, wcnt_d;
  logic          rbank_q, rbank_d;
  logic [IW-1:0] rcnt_q, rcnt_d;

  logic          wr_en, wr_last;
  logic          load, clr_full;
  logic [IW-1:0] rd_idx;

  // Bank storage: tile address is {bank, tile index}; no reset on data.
  logic [TW-1:0] b_mem [0:2*TPG-1];
  logic [TW-1:0] c_mem [0:2*TPG-1];
  logic [TW-1:0] h_mem [0:2*TPG-1];
  logic [DW-1:0] dt_mem [0:1];
  logic [DW-1:0] da_mem [0:1];
  logic [DW-1:0] x_mem  [0:1];
  logic [DW-1:0] d_mem  [0:1];

  logic          tile_valid_q;
  logic [DW-1:0] dt_q, da_q, x_q, d_q;
  logic [TW-1:0] b_q, c_q, h_q;
  logic [IW-1:0] idx_q;
  logic          last_q;
  logic [15:0]   groups_q;

  assign in_ready_o = ~full_q[wbank_q];
  assign wr_en      = in_valid_i & in_ready_o;
  assign wr_last    = wr_en & (wcnt_q == IW'(TPG-1));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      b_mem[{wbank_q, wcnt_q}] <= in_B_tile_i;
      c_mem[{wbank_q, wcnt_q}] <= in_C_tile_i;
      h_mem[{wbank_q, wcnt_q}] <= in_hprev_tile_i;
      if (wcnt_q == '0) begin
        dt_mem[wbank_q] <= in_dt_i;
        da_mem[wbank_q] <= in_dA_i;
        x_mem[wbank_q]  <= in_x_i;
        d_mem[wbank_q]  <= in_D_i;
      end
    end
  end

  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    if (wr_en) begin
      wcnt_d = wcnt_q + IW'(1);
      if (wr_last) wbank_d = ~wbank_q;
    end
  end

  // Read FSM: rcnt_q is the index of the next tile to load during BURST.
  always_comb begin
    state_d  = state_q;
    rbank_d  = rbank_q;
    rcnt_d   = rcnt_q;
    load     = 1'b0;
    clr_full = 1'b0;
    rd_idx   = '0;
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          load    = 1'b1;
          rd_idx  = '0;
          rcnt_d  = IW'(1);
          state_d = BURST;
        end
      end
      BURST: begin
        load   = 1'b1;
        rd_idx = rcnt_q;
        rcnt_d = rcnt_q + IW'(1);
        if (rcnt_q == IW'(TPG-1)) begin
          clr_full = 1'b1;
          rbank_d  = ~rbank_q;
          rcnt_d   = '0;
          state_d  = full_q[~rbank_q] ? BURST : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set and clear never hit the same bank on one edge.
  always_comb begin
    full_d = full_q;
    if (wr_last)  full_d[wbank_q] = 1'b1;
    if (clr_full) full_d[rbank_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      full_q  <= '0;
      wbank_q <= 1'b0;
      wcnt_q  <= '0;
      rbank_q <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      wbank_q <= wbank_d;
      wcnt_q  <= wcnt_d;
      rbank_q <= rbank_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Output registers hold the last tile when no new tile is loaded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tile_valid_q <= 1'b0;
      dt_q         <= '0;
      da_q         <= '0;
      x_q          <= '0;
      d_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      h_q          <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      groups_q     <= '0;
    end else begin
      tile_valid_q <= load;
      last_q       <= load & (rd_idx == IW'(TPG-1));
      if (clr_full) groups_q <= groups_q + 16'd1;
      if (load) begin
        b_q   <= b_mem[{rbank_q, rd_idx}];
        c_q   <= c_mem[{rbank_q, rd_idx}];
        h_q   <= h_mem[{rbank_q, rd_idx}];
        dt_q  <= dt_mem[rbank_q];
        da_q  <= da_mem[rbank_q];
        x_q   <= x_mem[rbank_q];
        d_q   <= d_mem[rbank_q];
        idx_q <= rd_idx;
      end
    end
  end

  assign tile_valid_o  = tile_valid_q;
  assign dt_o          = dt_q;
  assign dA_o          = da_q;
  assign x_o           = x_q;
  assign D_o           = d_q;
  assign B_tile_o      = b_q;
  assign C_tile_o      = c_q;
  assign hprev_tile_o  = h_q;
  assign tile_idx_o    = idx_q;
  assign group_last_o  = last_q;
  assign groups_sent_o = groups_q;

endmodule

// File: tb/tb_ssm_tile_feeder.sv
// Randomized bench for ssm_tile_feeder: a group-level model predicts which
// tile appears on which clock edge, plus ready and the group counter.
module tb_ssm_tile_feeder;
  localparam int DW      = 16;
  localparam int N_TILE  = 16;
  localparam int N_TOTAL = 128;
  localparam int TPG     = N_TOTAL / N_TILE;
  localparam int IW      = $clog2(TPG);
  localparam int TW      = N_TILE * DW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_dt_i, in_dA_i, in_x_i, in_D_i;
  logic [TW-1:0] in_B_tile_i, in_C_tile_i, in_hprev_tile_i;
  logic          tile_valid_o;
  logic [DW-1:0] dt_o, dA_o, x_o, D_o;
  logic [TW-1:0] B_tile_o, C_tile_o, hprev_tile_o;
  logic [IW-1:0] tile_idx_o;
  logic          group_last_o;
  logic [15:0]   groups_sent_o;

  always #5 clk = ~clk;

  ssm_tile_feeder #(.DW(DW), .N_TILE(N_TILE), .N_TOTAL(N_TOTAL)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_dt_i(in_dt_i), .in_dA_i(in_dA_i), .in_x_i(in_x_i), .in_D_i(in_D_i),
    .in_B_tile_i(in_B_tile_i), .in_C_tile_i(in_C_tile_i), .in_hprev_tile_i(in_hprev_tile_i),
    .tile_valid_o(tile_valid_o),
    .dt_o(dt_o), .dA_o(dA_o), .x_o(x_o), .D_o(D_o),
    .B_tile_o(B_tile_o), .C_tile_o(C_tile_o), .hprev_tile_o(hprev_tile_o),
    .tile_idx_o(tile_idx_o), .group_last_o(group_last_o), .groups_sent_o(groups_sent_o)
  );

  typedef struct {
    logic [TW-1:0] b, c, h;
    logic [DW-1:0] dt, da, x, d;
    int            idx;
    int            edge_n;
  } exp_t;

  exp_t          evq[$];
  int            cq[$];
  int            lq[$];
  int            done_c, done_l, last_end, cyc, beat;
  logic [TW-1:0] gb[TPG], gc[TPG], gh[TPG];
  logic [DW-1:0] gdt, gda, gx, gd;
  logic [TW-1:0] hold_b, hold_c, hold_h;
  logic [DW-1:0] hold_dt, hold_da, hold_x, hold_d;
  logic          hs;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_eq(string tag, logic [TW-1:0] obs, logic [TW-1:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    evq.delete(); cq.delete(); lq.delete();
    done_c = 0; done_l = 0; beat = 0; last_end = 0;
    hold_b = '0; hold_c = '0; hold_h = '0;
    hold_dt = '0; hold_da = '0; hold_x = '0; hold_d = '0;
  endtask

  // A completed group occupies TPG consecutive output cycles, starting one
  // edge after completion or right after the previous group, whichever is later.
  task automatic model_accept(int edge_n);
    int   start;
    exp_t e;
    gb[beat] = in_B_tile_i; gc[beat] = in_C_tile_i; gh[beat] = in_hprev_tile_i;
    if (beat == 0) begin
      gdt = in_dt_i; gda = in_dA_i; gx = in_x_i; gd = in_D_i;
    end
    if (beat == TPG-1) begin
      start = (edge_n + 1 > last_end + 1) ? edge_n + 1 : last_end + 1;
      for (int t = 0; t < TPG; t++) begin
        e.b = gb[t]; e.c = gc[t]; e.h = gh[t];
        e.dt = gdt; e.da = gda; e.x = gx; e.d = gd;
        e.idx = t; e.edge_n = start + t;
        evq.push_back(e);
      end
      last_end = start + TPG - 1;
      cq.push_back(edge_n);
      lq.push_back(last_end);
      beat = 0;
    end else begin
      beat++;
    end
  endtask

  task automatic step();
    exp_t e;
    hs = in_valid_i & in_ready_o;
    if (hs) model_accept(cyc + 1);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (cq.size() > 0 && cq[0] <= cyc) begin void'(cq.pop_front()); done_c++; end
    while (lq.size() > 0 && lq[0] <= cyc) begin void'(lq.pop_front()); done_l++; end
    check_eq("in_ready", TW'(in_ready_o), TW'((done_c - done_l) < 2));
    check_eq("groups_sent", TW'(groups_sent_o), TW'(16'(done_l)));
    if (evq.size() > 0 && evq[0].edge_n == cyc) begin
      e = evq.pop_front();
      check_eq("tile_valid", TW'(tile_valid_o), TW'(1));
      check_eq("tile_idx", TW'(tile_idx_o), TW'(e.idx));
      check_eq("group_last", TW'(group_last_o), TW'(e.idx == TPG-1));
      check_eq("B_tile", B_tile_o, e.b);
      check_eq("C_tile", C_tile_o, e.c);
      check_eq("hprev_tile", hprev_tile_o, e.h);
      check_eq("scalars", TW'({dt_o, dA_o, x_o, D_o}), TW'({e.dt, e.da, e.x, e.d}));
      hold_b = e.b; hold_c = e.c; hold_h = e.h;
      hold_dt = e.dt; hold_da = e.da; hold_x = e.x; hold_d = e.d;
    end else begin
      check_eq("tile_valid_idle", TW'(tile_valid_o), TW'(0));
      check_eq("group_last_idle", TW'(group_last_o), TW'(0));
      check_eq("B_hold", B_tile_o, hold_b);
      check_eq("C_hold", C_tile_o, hold_c);
      check_eq("hprev_hold", hprev_tile_o, hold_h);
      check_eq("scalar_hold", TW'({dt_o, dA_o, x_o, D_o}), TW'({hold_dt, hold_da, hold_x, hold_d}));
    end
  endtask

  // mode 0: lane value = tile*16+lane, dt=0x3C00; mode 1: random data.
  // Scalars on beats after beat 0 are always random so they must be ignored.
  task automatic send_groups(int n, int gmin, int gmax, int mode);
    int k;
    for (int g = 0; g < n; g++) begin
      for (int t = 0; t < TPG; t++) begin
        for (int l = 0; l < N_TILE; l++) begin
          if (mode == 0) begin
            in_B_tile_i[l*DW +: DW]     = DW'(t * 16 + l);
            in_C_tile_i[l*DW +: DW]     = DW'(t * 16 + l) ^ 16'h1000;
            in_hprev_tile_i[l*DW +: DW] = DW'(t * 16 + l) ^ 16'h2000;
          end else begin
            in_B_tile_i[l*DW +: DW]     = DW'($urandom);
            in_C_tile_i[l*DW +: DW]     = DW'($urandom);
            in_hprev_tile_i[l*DW +: DW] = DW'($urandom);
          end
        end
        if (mode == 0 && t == 0) begin
          in_dt_i = 16'h3C00; in_dA_i = 16'h1234; in_x_i = 16'h5678; in_D_i = 16'h9ABC;
        end else begin
          in_dt_i = DW'($urandom); in_dA_i = DW'($urandom);
          in_x_i  = DW'($urandom); in_D_i  = DW'($urandom);
        end
        in_valid_i = 1'b1;
        k = 0;
        do begin
          step();
          k++;
        end while (!hs && k < 300);
        if (!hs) begin
          check_eq("hs_timeout", TW'(hs), TW'(1));
          in_valid_i = 1'b0;
          return;
        end
        in_valid_i = 1'b0;
        repeat ($urandom_range(gmax, gmin)) step();
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while (evq.size() > 0 && k < 400) begin step(); k++; end
    check_eq("drain_done", TW'(evq.size()), TW'(0));
    repeat (3) step();
  endtask

  initial begin
    int k;
    rstn = 1'b0; in_valid_i = 1'b0;
    in_dt_i = '0; in_dA_i = '0; in_x_i = '0; in_D_i = '0;
    in_B_tile_i = '0; in_C_tile_i = '0; in_hprev_tile_i = '0;
    cyc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", TW'(in_ready_o), TW'(1));
    check_eq("rst_valid", TW'(tile_valid_o), TW'(0));
    check_eq("rst_ctrl", TW'({tile_idx_o, group_last_o, groups_sent_o}), TW'(0));
    check_eq("rst_data", B_tile_o | C_tile_o | hprev_tile_o, TW'(0));
    rstn = 1'b1;

    send_groups(1, 0, 0, 0);  drain();   // single patterned group
    send_groups(1, 0, 0, 1);  drain();   // scalar hold with changing scalars
    send_groups(1, 3, 3, 1);  drain();   // bursty: three idle cycles per beat
    send_groups(3, 0, 0, 1);  drain();   // back-to-back groups
    send_groups(4, 0, 1, 1);  drain();   // sustained pressure

    // Reset while tile 4 of a group is on the outputs.
    send_groups(1, 0, 0, 1);
    k = 0;
    while (!(tile_valid_o && tile_idx_o == IW'(4)) && k < 50) begin step(); k++; end
    check_eq("reach_tile4", TW'(tile_valid_o && tile_idx_o == IW'(4)), TW'(1));
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_valid", TW'(tile_valid_o), TW'(0));
    check_eq("mid_rst_ctrl", TW'({tile_idx_o, group_last_o, groups_sent_o}), TW'(0));
    check_eq("mid_rst_data", B_tile_o | C_tile_o | hprev_tile_o, TW'(0));
    check_eq("mid_rst_scalars", TW'({dt_o, dA_o, x_o, D_o}), TW'(0));
    check_eq("mid_rst_ready", TW'(in_ready_o), TW'(1));
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (10) step();
    send_groups(1, 0, 0, 0);  drain();

    send_groups(6, 0, 4, 1);  drain();   // random gaps

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
